uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: payload bits per frame, legal 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: tick strobes per bit period, even, legal 8..64.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked, legal 1 or 2.
REQ-005 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port tick  input  1  one-cycle oversample enable, OVERSAMPLE per bit period.
REQ-008 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data  output  DATA_BITS  received payload, LSB = first bit received.
REQ-010 SHALL have port rx_valid  output  1  rx_data holds an unconsumed frame.
REQ-011 SHALL have port rx_ready  input  1  consumer accepts frame when rx_valid&&rx_ready.
REQ-012 SHALL have port parity_err  output  1  parity mismatch for the frame in rx_data.
REQ-013 SHALL have port frame_err  output  1  a stop bit sampled 0 for the frame in rx_data.
REQ-014 SHALL have port break_det  output  1  one-cycle pulse on break detection.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s.
REQ-018 SHALL implement states IDLE, START, DATA, PAR, STOP, RECOVER; tick-counter c and bit-counter advance only on cycles with tick=1, and everything holds otherwise.
REQ-019 SHALL, in IDLE, on rx_s==0, enter START with c=0.
REQ-020 SHALL count each bit period as c=0..OVERSAMPLE-1, sample rx_s at c=OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1, and take the bit value as the 2-of-3 majority.
REQ-021 SHALL treat a START majority of 1 as a false start: return to IDLE at c=OVERSAMPLE/2+1 with no output change.
REQ-022 SHALL shift DATA_BITS bits LSB-first in DATA; after the last bit, enter PAR if PARITY!=0, else STOP.
REQ-023 SHALL set the parity result to 1 when (XOR of data bits ^ parity bit) differs from 1 (odd) or 0 (even).
REQ-024 SHALL check STOP_BITS stop bits; any stop majority 0 sets the frame error.
REQ-025 SHALL complete the frame at c=OVERSAMPLE/2+1 of the last stop bit (half-bit early), giving back-to-back frame tolerance.
REQ-026 SHALL, at completion, go to IDLE if the frame error is 0, else to RECOVER; RECOVER returns to IDLE only when rx_s==1.
REQ-027 SHALL, at completion with rx_valid==0 or a handshake in the same cycle, load rx_data, parity_err and frame_err on the next edge and set rx_valid=1.
REQ-028 SHALL, at completion with rx_valid==1 and rx_ready==0, drop the new frame, keep rx_data and flags, and pulse overrun for one cycle.
REQ-029 SHALL clear rx_valid on the edge after rx_valid&&rx_ready with no concurrent completion; rx_ready is ignored when rx_valid==0.
REQ-030 SHALL pulse break_det when all data bits, the parity bit (if any) and the first stop bit are 0; the frame is still delivered with frame_err=1.
REQ-031 SHALL have one-frame reception latency: rx_valid rises exactly 1 clk after the completion tick.

Reset
REQ-032 SHALL, on rst, asynchronously force state IDLE, c=0, synchronizer flops to 1, rx_data=0, and rx_valid, parity_err, frame_err, break_det, overrun and busy to 0.
REQ-033 SHALL abandon a frame in progress on rst, deliver nothing from it, and treat the first falling edge after release as a new start.

Verification (OVERSAMPLE=16, DATA_BITS=8, STOP_BITS=1 unless noted)
REQ-034 SHALL cover: PARITY=0, frame 0xA5, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, both error flags 0.
REQ-035 SHALL cover: PARITY=2, 0x3C sent with parity bit 1 -> rx_data=0x3C, parity_err=1, frame_err=0.
REQ-036 SHALL cover: rx low for 12 bit periods, then high -> break_det one pulse, rx_data=0x00, frame_err=1, busy high until rx high, and no second frame.
REQ-037 SHALL cover: rx low for 4 ticks only -> false start, rx_valid stays 0; a 1-tick glitch at c=8 of a data bit -> bit value unchanged.
REQ-038 SHALL cover: 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x11 retained, overrun one pulse; a third frame 0x33 after rx_ready=1 is received correctly.
REQ-039 SHALL cover: rst asserted mid-DATA -> all outputs 0 immediately; a following frame 0x5A -> rx_data=0x5A, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with 2-of-3 voting, parity/frame/break checks and a valid/ready output stage
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_LO  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_HI  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, RECOVER} state_t;
  state_t state, state_n;
  logic [CW-1:0] c;
  logic [BW-1:0] n;
  logic [DATA_BITS-1:0] sh;
  logic rx_m, rx_s, v0, v1, pbit, fe_r, brk_r;
  logic maj, decide, last_c, done, fe_now, brk_now, pe_now;
  assign maj     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign decide  = tick && c == C_HI;
  assign last_c  = tick && c == C_END;
  assign fe_now  = fe_r | ~maj;
  assign brk_now = (n == '0) ? (~|sh & ~pbit & ~maj) : brk_r;
  assign pe_now  = (PARITY != 0) && ((^sh ^ pbit) != (PARITY == 1));
  assign busy    = state != IDLE;
  // two-flop synchronizer, idles high out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state; every transition waits for a tick, frame completes mid last stop bit
  always_comb begin
    state_n = state;
    done = 1'b0;
    unique case (state)
      IDLE:    if (tick && !rx_s) state_n = START;
      START:   if (decide && maj) state_n = IDLE;
               else if (last_c) state_n = DATA;
      DATA:    if (last_c && n == BW'(DATA_BITS - 1)) state_n = (PARITY != 0) ? PAR : STOP;
      PAR:     if (last_c) state_n = STOP;
      STOP:    if (decide && n == BW'(STOP_BITS - 1)) begin
                 done = 1'b1;
                 state_n = fe_now ? RECOVER : IDLE;
               end
      RECOVER: if (tick && rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // tick/bit counters, vote samples, shift register and per-frame error accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      n <= '0;
      sh <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      pbit <= 1'b0;
      fe_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (tick) begin
      c <= (state_n != state || c == C_END || state == IDLE) ? '0 : c + 1'b1;
      n <= (state_n != state) ? '0 : (c == C_END) ? n + 1'b1 : n;
      if (c == C_LO) v0 <= rx_s;
      if (c == C_MID) v1 <= rx_s;
      if (state == DATA && c == C_HI) sh <= {maj, sh[DATA_BITS-1:1]};
      if (state == START) pbit <= 1'b0;
      else if (state == PAR && c == C_HI) pbit <= maj;
      if (state == START) fe_r <= 1'b0;
      else if (state == STOP && c == C_HI) fe_r <= fe_now;
      if (state == STOP && c == C_HI && n == '0) brk_r <= brk_now;
    end
  end
  // output stage: deliver on free slot or same-cycle handshake, otherwise drop and flag overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      overrun <= 1'b0;
    end else begin
      rx_valid <= done | (rx_valid & ~rx_ready);
      overrun <= done & rx_valid & ~rx_ready;
      break_det <= done & brk_now;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data <= sh;
        parity_err <= pe_now;
        frame_err <= fe_now;
      end
    end
  end
endmodule
